// File: rtl/mxv_sched_if.sv
// Datapath-side bundle of the matrix-vector sequencer: FIFO A pop, vector
// address, MAC strobes and the transmitter handshake.
interface mxv_sched_if #(
  parameter int AW = 3
);
  logic          a_empty;
  logic          a_pop;
  logic [AW-1:0] b_addr;
  logic          mac_clr;
  logic          mac_en;
  logic          mac_last;
  logic          tx_ready;
  logic          transmit;

  modport master (
    input  a_empty, tx_ready,
    output a_pop, b_addr, mac_clr, mac_en, mac_last, transmit
  );

  modport slave (
    output a_empty, tx_ready,
    input  a_pop, b_addr, mac_clr, mac_en, mac_last, transmit
  );
endinterface

// File: rtl/mxv_sched.sv
// Row-by-row sequencer for the matrix-vector product: pops FIFO A, steps the
// vector address, strobes the MAC and hands each row result to the UART.
module mxv_sched #(
  parameter int NW    = 4,
  parameter int MAX_N = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clear,
  input  logic [NW-1:0] n,
  mxv_sched_if.master   dp,
  output logic [AW-1:0] row_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // One extra bit so that n_q = MAX_N = 2**AW never wraps the counters.
  localparam int CW = AW + 1;
  localparam logic [NW:0]   MAX_N_W = (NW + 1)'(MAX_N);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_TAIL,
    S_SEND,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] col, col_d;
  logic [CW-1:0] row, row_d;
  logic [CW-1:0] n_q, n_d;
  logic          mac_en_q, mac_en_d;
  logic          mac_last_q, mac_last_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic          err_q, err_d;
  logic          a_pop_c, mac_clr_c, transmit_c, done_c;
  logic          n_legal, last_col, last_row;

  assign n_legal  = (n != '0) && ({1'b0, n} <= MAX_N_W);
  assign last_col = (col == n_q - ONE);
  assign last_row = (row == n_q - ONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      n_q        <= '0;
      mac_en_q   <= 1'b0;
      mac_last_q <= 1'b0;
      b_addr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_d;
      col        <= col_d;
      row        <= row_d;
      n_q        <= n_d;
      mac_en_q   <= mac_en_d;
      mac_last_q <= mac_last_d;
      b_addr_q   <= b_addr_d;
      err_q      <= err_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    col_d      = col;
    row_d      = row;
    n_d        = n_q;
    mac_en_d   = 1'b0;
    mac_last_d = 1'b0;
    b_addr_d   = '0;
    err_d      = 1'b0;
    a_pop_c    = 1'b0;
    mac_clr_c  = 1'b0;
    transmit_c = 1'b0;
    done_c     = 1'b0;

    if (clear) begin
      // Abort wins over everything, including a coincident start.
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
      n_d     = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (n_legal) begin
              n_d     = CW'(n);
              row_d   = '0;
              state_d = S_CLR;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        S_CLR: begin
          mac_clr_c = 1'b1;
          col_d     = '0;
          state_d   = S_RUN;
        end

        S_RUN: begin
          if (!dp.a_empty) begin
            // The MAC consumes the popped word one cycle later, together
            // with the column it belongs to.
            a_pop_c    = 1'b1;
            col_d      = col + ONE;
            mac_en_d   = 1'b1;
            mac_last_d = last_col;
            b_addr_d   = col[AW-1:0];
            if (last_col) begin
              state_d = S_TAIL;
            end
          end
        end

        S_TAIL: begin
          state_d = S_SEND;
        end

        S_SEND: begin
          if (dp.tx_ready) begin
            transmit_c = 1'b1;
            if (last_row) begin
              state_d = S_DONE;
            end else begin
              row_d   = row + ONE;
              state_d = S_CLR;
            end
          end
        end

        S_DONE: begin
          done_c  = 1'b1;
          row_d   = '0;
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Registered strobes are gated so an abort silences them in its own cycle.
  assign dp.a_pop    = a_pop_c;
  assign dp.mac_clr  = mac_clr_c;
  assign dp.mac_en   = mac_en_q & ~clear;
  assign dp.mac_last = mac_last_q & ~clear;
  assign dp.b_addr   = b_addr_q;
  assign dp.transmit = transmit_c;
  assign done        = done_c;
  assign err         = err_q & ~clear;
  assign busy        = (state != S_IDLE);
  assign row_idx     = row[AW-1:0];

endmodule

// File: tb/tb_mxv_sched.sv
// Scoreboard bench for mxv_sched: expected strobe events are queued with their
// cycle numbers at launch and matched as the sequencer emits them.
module tb_mxv_sched;

  localparam int NW    = 4;
  localparam int MAX_N = 8;
  localparam int AW    = 3;
  localparam int NOCUT = 1_000_000;

  typedef struct {
    int          cyc;
    logic [AW-1:0] b;
    logic        last;
  } mac_t;

  typedef struct {
    int cyc;
    int row;
  } tx_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          clear;
  logic [NW-1:0] n;
  logic [AW-1:0] row_idx;
  logic          busy;
  logic          done;
  logic          err;

  mxv_sched_if #(.AW(AW)) dp ();

  mxv_sched #(.NW(NW), .MAX_N(MAX_N), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clear   (clear),
    .n       (n),
    .dp      (dp),
    .row_idx (row_idx),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;

  int   q_clr[$];
  int   q_pop[$];
  int   q_done[$];
  int   q_err[$];
  mac_t q_mac[$];
  tx_t  q_tx[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected event timeline for one product; stall_len idle cycles of FIFO A
  // before column 1 of row 0, tx_wait cycles of tx_ready low in row 0's SEND,
  // and events at or after relative cycle 'cut' dropped (abort point).
  task automatic push_run(input int nv, input int stall_len, input int tx_wait,
                          input int cut);
    int t;
    mac_t m;
    tx_t  x;
    t = 1;
    for (int r = 0; r < nv; r++) begin
      if (t < cut) q_clr.push_back(t0 + t);
      t++;
      for (int c = 0; c < nv; c++) begin
        if (r == 0 && c == 1) t += stall_len;
        if (t < cut) q_pop.push_back(t0 + t);
        if (t + 1 < cut) begin
          m.cyc  = t0 + t + 1;
          m.b    = AW'(c);
          m.last = (c == nv - 1);
          q_mac.push_back(m);
        end
        t++;
      end
      t++;
      if (r == 0) t += tx_wait;
      if (t < cut) begin
        x.cyc = t0 + t;
        x.row = r;
        q_tx.push_back(x);
      end
      t++;
    end
    if (t < cut) q_done.push_back(t0 + t);
  endtask

  task automatic launch(input int nv, input int stall_len, input int tx_wait,
                        input int cut);
    @(posedge clk);
    #1;
    t0 = cyc;
    if (nv < 1 || nv > MAX_N) q_err.push_back(t0 + 1);
    else push_run(nv, stall_len, tx_wait, cut);
    n     = NW'(nv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc < t0 + r) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_check(input string tag);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_clr_left"},  q_clr.size(),  0);
    check({tag, "_pop_left"},  q_pop.size(),  0);
    check({tag, "_mac_left"},  q_mac.size(),  0);
    check({tag, "_tx_left"},   q_tx.size(),   0);
    check({tag, "_done_left"}, q_done.size(), 0);
    check({tag, "_err_left"},  q_err.size(),  0);
    check({tag, "_busy"},      busy,          0);
    check({tag, "_row_idx"},   row_idx,       0);
  endtask

  // Event monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    mac_t m;
    tx_t  x;
    int   c;
    if (dp.a_pop) begin
      check("pop_while_empty", dp.a_empty, 0);
      check("pop_expected", q_pop.size() > 0, 1);
      if (q_pop.size() > 0) begin
        c = q_pop.pop_front();
        check("pop_cycle", cyc, c);
      end
    end
    if (dp.mac_clr) begin
      check("clr_expected", q_clr.size() > 0, 1);
      if (q_clr.size() > 0) begin
        c = q_clr.pop_front();
        check("clr_cycle", cyc, c);
      end
    end
    if (dp.mac_last) check("last_with_en", dp.mac_en, 1);
    if (dp.mac_en) begin
      check("mac_expected", q_mac.size() > 0, 1);
      if (q_mac.size() > 0) begin
        m = q_mac.pop_front();
        check("mac_cycle", cyc, m.cyc);
        check("mac_b_addr", dp.b_addr, m.b);
        check("mac_last", dp.mac_last, m.last);
      end
    end
    if (dp.transmit) begin
      check("tx_expected", q_tx.size() > 0, 1);
      if (q_tx.size() > 0) begin
        x = q_tx.pop_front();
        check("tx_cycle", cyc, x.cyc);
        check("tx_row_idx", row_idx, x.row);
      end
    end
    if (done) begin
      check("done_busy", busy, 1);
      check("done_expected", q_done.size() > 0, 1);
      if (q_done.size() > 0) begin
        c = q_done.pop_front();
        check("done_cycle", cyc, c);
      end
    end
    if (err) begin
      check("err_expected", q_err.size() > 0, 1);
      if (q_err.size() > 0) begin
        c = q_err.pop_front();
        check("err_cycle", cyc, c);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    clear       = 1'b0;
    n           = '0;
    dp.a_empty  = 1'b0;
    dp.tx_ready = 1'b1;

    // Reset state: everything quiet for 10 cycles after release.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("reset_outputs",
            int'({dp.a_pop, dp.mac_clr, dp.mac_en, dp.mac_last, dp.transmit,
                  done, err, busy, dp.b_addr, row_idx}), 0);
    end

    // n=2, no stalls.
    launch(2, 0, 0, NOCUT);
    wait_rel(12);
    drain_check("n2");

    // n=3 with FIFO A empty for 4 cycles after the first pop.
    launch(3, 4, 0, NOCUT);
    wait_rel(3);
    dp.a_empty = 1'b1;
    wait_rel(7);
    dp.a_empty = 1'b0;
    wait_rel(26);
    drain_check("n3_stall");

    // n=1 with transmitter busy for the first 5 SEND cycles.
    dp.tx_ready = 1'b0;
    launch(1, 0, 5, NOCUT);
    wait_rel(9);
    dp.tx_ready = 1'b1;
    wait_rel(12);
    drain_check("n1_txwait");

    // Illegal sizes.
    launch(0, 0, 0, NOCUT);
    @(negedge clk);
    check("err_n0_busy", busy, 0);
    drain_check("n0");
    launch(MAX_N + 1, 0, 0, NOCUT);
    @(negedge clk);
    check("err_n9_busy", busy, 0);
    drain_check("n9");

    // clear coincident with start wins.
    @(posedge clk);
    #1;
    n     = NW'(2);
    start = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    check("clear_start_busy", busy, 0);
    drain_check("clear_start");

    // n=4, abort during RUN of row 2 (row 2 runs from relative cycle 16).
    launch(4, 0, 0, 17);
    wait_rel(17);
    clear = 1'b1;
    @(negedge clk);
    check("clear_row", row_idx, 2);
    check("clear_strobes",
          int'({dp.a_pop, dp.mac_en, dp.mac_last, dp.mac_clr, dp.transmit, done}), 0);
    wait_rel(18);
    clear = 1'b0;
    @(negedge clk);
    check("clear_idle_busy", busy, 0);
    drain_check("n4_clear");
    launch(2, 0, 0, NOCUT);
    wait_rel(12);
    drain_check("n2_after_clear");

    // Same abort point, this time by reset.
    launch(4, 0, 0, 17);
    wait_rel(17);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_strobes",
          int'({dp.a_pop, dp.mac_en, dp.mac_last, dp.mac_clr, dp.transmit, done, err}), 0);
    wait_rel(19);
    rst = 1'b1;
    drain_check("n4_rst");
    launch(2, 0, 0, NOCUT);
    wait_rel(12);
    drain_check("n2_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
